// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared configuration for the single-clock FIFO: default
//               geometry, pointer-width helper and the occupancy count type.
//               Optional feature macro used by this block:
//               SYNC_FIFO_ERR_FLAGS_EN (adds overflow/underflow outputs).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  // Default geometry; DEPTH must be a power of two and at least 2.
  localparam int unsigned C_DATA_W_DEF = 8;
  localparam int unsigned C_DEPTH_DEF  = 16;

  // Pointer width for a given depth. Pointers wrap naturally, which only
  // works because DEPTH is a power of two.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned C_PTR_W_DEF = ptr_width(C_DEPTH_DEF);

  // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
  typedef logic [C_PTR_W_DEF:0] count_t;

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_if
// Description : Producer/consumer bus of the single-clock FIFO.
//               master : drives rd, wr, data_in; observes data_out and flags
//               slave  : the FIFO itself
//               With SYNC_FIFO_ERR_FLAGS_EN defined the bus also carries the
//               registered overflow/underflow pulses.
// Signals     : rd, wr      - read / write requests
//               data_in     - write data (DATA_W)
//               data_out    - registered read data (DATA_W)
//               empty, full - occupancy status
//               overflow, underflow (optional) - dropped-request pulses
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W_DEF
);

  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  modport master (
    output rd, wr, data_in,
    input  data_out, empty, full, overflow, underflow
  );

  modport slave (
    input  rd, wr, data_in,
    output data_out, empty, full, overflow, underflow
  );
`else
  modport master (
    output rd, wr, data_in,
    input  data_out, empty, full
  );

  modport slave (
    input  rd, wr, data_in,
    output data_out, empty, full
  );
`endif

endinterface : sync_fifo_if
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x DATA_W register array with one write port and one
//               registered read port. The array itself is never reset; only
//               the read-data register is, so data_out starts at zero.
//               A read and a write to the same address in the same cycle
//               return the old contents (read-before-write), which is what
//               the FIFO relies on when it is full and reads/writes at once.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (read register only)
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               re_i     - read enable; rdata_o holds when low
//               raddr_i  - read address
//               rdata_o  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W_DEF,
  parameter int unsigned DEPTH  = C_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [ptr_width(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic                        re_i,
  input  logic [ptr_width(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]           rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage: no reset, contents survive a FIFO reset but become unreachable
  // because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO for DATA_W-bit words, DEPTH entries.
//               Writes to a full FIFO (without a simultaneous read) and reads
//               from an empty FIFO are dropped. Read data is registered with
//               one cycle of latency and holds between reads.
//               Optional macro SYNC_FIFO_ERR_FLAGS_EN adds registered
//               overflow/underflow pulses reporting dropped requests.
// Ports       : clk    - clock, all state on the rising edge
//               rst_n  - synchronous reset, ACTIVE-HIGH (name kept for
//                        compatibility with existing integrations)
//               bus    - sync_fifo_if.slave: rd, wr, data_in, data_out,
//                        empty, full [, overflow, underflow]
// Parameters  : DATA_W - word width
//               DEPTH  - entries, power of two and >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W_DEF,
  parameter int unsigned DEPTH  = C_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_fifo_if.slave bus
);

  localparam int unsigned c_ptr_w = ptr_width(DEPTH);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_count_full = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_count_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q,  count_d;

  logic              w_empty;
  logic              w_full;
  logic              w_wr_accept;
  logic              w_rd_accept;
  logic [DATA_W-1:0] w_rdata;

  // --------------------------------------------------------------------------
  // Status flags: plain decodes of the registered count.
  // --------------------------------------------------------------------------
  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_count_full);

  // --------------------------------------------------------------------------
  // Accept logic
  // A write while full is still taken when a read frees the slot in the same
  // cycle. A read is never taken while empty, even with a concurrent write:
  // the new word is not yet in the array.
  // --------------------------------------------------------------------------
  assign w_wr_accept = bus.wr & (~w_full | bus.rd);
  assign w_rd_accept = bus.rd & ~w_empty;

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pointers wrap modulo DEPTH through natural overflow.
    if (w_wr_accept) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end
    if (w_rd_accept) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    case ({w_wr_accept, w_rd_accept})
      2'b10:   count_d = count_q + c_count_one;
      2'b01:   count_d = count_q - c_count_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst_n),
    .we_i    (w_wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (w_rd_accept),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_rdata)
  );

  assign bus.data_out = w_rdata;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;

  // --------------------------------------------------------------------------
  // Optional dropped-request reporting, one-cycle pulses.
  // --------------------------------------------------------------------------
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // A write is only lost when full and no read is freeing a slot.
      overflow_q  <= bus.wr & w_full & ~bus.rd;
      // Any read seen while empty is lost, including one paired with a write.
      underflow_q <= bus.rd & w_empty;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. A queue-based reference
//               model is compared against the DUT every cycle, and directed
//               scenarios carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;

  logic clk;
  logic rst_n;

  sync_fifo_if #(.DATA_W(DW)) bus ();

  sync_fifo #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of stored words. Inputs change only just after
  // a rising edge, so at the falling edge they equal what the next rising
  // edge samples; the model first checks the current state, then advances.
  // --------------------------------------------------------------------------
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_dout;
  bit            m_ovf;
  bit            m_unf;
  bit            model_on = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      chk("model.data_out", bus.data_out, m_dout);
      chk("model.empty",    bus.empty,    (m_q.size() == 0));
      chk("model.full",     bus.full,     (m_q.size() == DP));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("model.overflow",  bus.overflow,  m_ovf);
      chk("model.underflow", bus.underflow, m_unf);
`endif
    end
    if (rst_n) begin
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      automatic int  sz = m_q.size();
      automatic bit  rd_ok = bus.rd && (sz > 0);
      automatic bit  wr_ok = bus.wr && ((sz < DP) || bus.rd);
      m_ovf = bus.wr && (sz == DP) && !bus.rd;
      m_unf = bus.rd && (sz == 0);
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(bus.data_in);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit r, input bit w, input logic [DW-1:0] d);
    bus.rd      = r;
    bus.wr      = w;
    bus.data_in = d;
    tick();
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
  endtask

  task automatic fill_1_to_16();
    for (int i = 1; i <= DP; i++) do_op(1'b0, 1'b1, DW'(i));
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b1;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.data_in = '0;

    // ---- Reset ----
    repeat (2) @(posedge clk);
    #1;
    model_on = 1'b1;
    chk("reset.empty",    bus.empty,    1);
    chk("reset.full",     bus.full,     0);
    chk("reset.data_out", bus.data_out, 8'h00);
    rst_n = 1'b0;
    do_op(1'b1, 1'b0, 8'h00);
    chk("rd_after_reset.data_out", bus.data_out, 8'h00);
    chk("rd_after_reset.empty",    bus.empty,    1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rd_after_reset.underflow", bus.underflow, 1);
`endif

    // ---- Fill / drain ----
    fill_1_to_16();
    chk("fill.full",  bus.full,  1);
    chk("fill.empty", bus.empty, 0);
    do_op(1'b0, 1'b1, 8'hFF);
    chk("wr_full.full", bus.full, 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("wr_full.overflow", bus.overflow, 1);
`endif
    for (int i = 1; i <= DP; i++) begin
      do_op(1'b1, 1'b0, 8'h00);
      chk("drain.data_out", bus.data_out, 32'(i));
    end
    chk("drain.empty", bus.empty, 1);
    chk("drain.full",  bus.full,  0);

    // ---- Simultaneous rd/wr while empty ----
    do_op(1'b1, 1'b1, 8'hA5);
    chk("rw_empty.empty",    bus.empty,    0);
    chk("rw_empty.data_out", bus.data_out, 8'h10);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rw_empty.underflow", bus.underflow, 1);
`endif
    do_op(1'b1, 1'b0, 8'h00);
    chk("rw_empty.read", bus.data_out, 8'hA5);
    chk("rw_empty.empty_after", bus.empty, 1);

    // ---- Simultaneous rd/wr while full ----
    fill_1_to_16();
    do_op(1'b1, 1'b1, 8'h77);
    chk("rw_full.data_out", bus.data_out, 8'h01);
    chk("rw_full.full",     bus.full,     1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rw_full.overflow", bus.overflow, 0);
`endif
    for (int i = 2; i <= DP; i++) begin
      do_op(1'b1, 1'b0, 8'h00);
      chk("rw_full.drain", bus.data_out, 32'(i));
    end
    do_op(1'b1, 1'b0, 8'h00);
    chk("rw_full.last", bus.data_out, 8'h77);
    chk("rw_full.empty", bus.empty, 1);

    // ---- Random interleaved traffic (model checks every cycle) ----
    for (int i = 0; i < 40; i++) begin
      automatic bit w = ($urandom_range(0, 9) < 6);
      automatic bit r = ($urandom_range(0, 9) < 5);
      do_op(r, w, DW'($urandom_range(0, 255)));
    end
    // A longer write burst pushes the pointers around the ring again.
    for (int i = 0; i < 20; i++) do_op(1'b0, 1'b1, DW'($urandom_range(0, 255)));
    for (int i = 0; i < 20; i++) do_op(1'b1, 1'b0, 8'h00);
    chk("random.empty_after_drain", bus.empty, 1);

    // ---- Reset mid-stream ----
    for (int i = 0; i < 5; i++) do_op(1'b0, 1'b1, DW'(8'h50 + i));
    chk("mid.empty_before", bus.empty, 0);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("mid.empty",    bus.empty,    1);
    chk("mid.full",     bus.full,     0);
    chk("mid.data_out", bus.data_out, 8'h00);
    do_op(1'b0, 1'b1, 8'h3C);
    chk("mid.empty_after_wr", bus.empty, 0);
    do_op(1'b1, 1'b0, 8'h00);
    chk("mid.read", bus.data_out, 8'h3C);
    chk("mid.empty_after_rd", bus.empty, 1);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sync_fifo
`default_nettype wire
